lab1_imul_dot_accum: RTL
========================

// Module: lab1_imul_dot_accum
// PURPOSE
//  Downstream consumer of the integer multiplier's 32-bit product stream.
//  Sums every group of p_nelems consecutive products into one dot-product
//  result and emits that result on a val/rdy output stream.
//  Sits between the multiplier ostream and the sink/next stage.
// PARAMETERS
//  p_nelems  4   products per dot product; legal range 1..256
//  p_nbits   32  product and accumulator width
// PORTS
//  clk          in   1        clock
//  reset        in   1        reset, synchronous, active-high
//  istream_val  in   1        product valid (from multiplier ostream_val)
//  istream_rdy  out  1        accumulator ready for a product
//  istream_msg  in   p_nbits  product value
//  ostream_val  out  1        dot-product result valid
//  ostream_rdy  in   1        downstream ready
//  ostream_msg  out  p_nbits  dot-product result
// BEHAVIOUR
//  - Reset: state=ACCUM, acc=0, count=0, ostream_val=0, ostream_msg=0,
//    istream_rdy=1 in the first cycle after reset deasserts.
//  - Reset mid-group or while in DONE discards the partial/pending sum.
//  - istream_rdy = (state==ACCUM); ostream_val = (state==DONE).
//    Both are decoded combinationally from the state register.
//  - ostream_msg = acc, driven straight from the register.
//  - Fire rules: in_fire = istream_val&istream_rdy;
//    out_fire = ostream_val&ostream_rdy.
//  - ACCUM, on in_fire: acc<=acc+istream_msg; count<=count+1.
//    If count==p_nelems-1 at that fire, go to DONE.
//  - DONE: acc is held stable while ostream_rdy=0 (no drop, no change).
//    On out_fire: acc<=0, count<=0, go to ACCUM.
//  - No input is accepted in DONE.
//  - Latency: result is valid in the cycle after the last product is accepted.
//  - Throughput: 1 product/cycle, plus 1 result cycle per group; peak is
//    p_nelems+1 cycles per dot product.
//  - count width: $clog2(p_nelems+1). With p_nelems=1 the FSM toggles
//    ACCUM<->DONE on every product.
//  - Arithmetic: unsigned p_nbits add. Default wraps modulo 2^p_nbits
//    (see CONFIGURATION).
//  - An unused state encoding returns to ACCUM with acc=0, count=0.
// CONFIGURATION
//  LAB1_IMUL_DOT_ACCUM_SAT_EN
//   - defined: saturating accumulate. If the carry-out of acc+istream_msg
//     is 1, acc<={p_nbits{1'b1}} and stays there until the group ends.
//   - undefined: wrap-around accumulate; carry-out is ignored.
// STRUCTURE
//  - Package lab1_imul_dot_accum_pkg:
//    - state enum {ACCUM, DONE} (1 bit)
//    - localparam c_sat_max = all-ones of p_nbits
//  - Sub-module lab1_imul_sat_adder: combinational p_nbits adder with
//    carry-out. Its saturation mux is present only under the macro.
//  - Top: state register, acc/count registers, next-state and output logic.
//  - Line trace format: istream val/rdy/msg, then (A|D and count), then
//    ostream val/rdy/msg.
// TESTING
//  1. p_nelems=4; products 1,2,3,4 back-to-back, ostream_rdy=1
//     -> ostream_msg=10 on cycle 5; istream_rdy=0 on that cycle.
//  2. Two groups back-to-back (1,1,1,1 then 5,5,5,5)
//     -> results 4 then 20; acc clears between groups.
//  3. Result pending with ostream_rdy=0 for 3 cycles
//     -> ostream_val=1 and msg stable for all 3 cycles; istream_rdy=0 throughout.
//  4. Random istream_val gaps (products 7,0,9,2)
//     -> result 18; count advances only on in_fire.
//  5. Products 32'hFFFF_FFFF then 2,0,0
//     -> result 1 without the macro; 32'hFFFF_FFFF with
//        LAB1_IMUL_DOT_ACCUM_SAT_EN.
//  6. Reset after 2 of 4 products, then send 3,3,3,3
//     -> result 12; ostream_val=0 during reset.

Source files
------------

// File: rtl/lab1_imul_dot_accum_pkg.sv
// Shared types and constants for the dot-product accumulator.
//   state_e   : accumulator FSM state (ACCUM collects products, DONE presents result)
//   c_nbits   : default product/accumulator width
//   c_sat_max : saturation ceiling at the default width
package lab1_imul_dot_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam int unsigned       c_nbits   = 32;
  localparam logic [c_nbits-1:0] c_sat_max = '1;

endpackage

// File: rtl/lab1_imul_sat_adder.sv
// Combinational unsigned adder with carry-out.
// Build option: LAB1_IMUL_DOT_ACCUM_SAT_EN clamps the sum to all-ones on carry-out;
// otherwise the sum wraps modulo 2^p_nbits.
// Ports:
//   in0, in1 : addends
//   sum      : result (wrapped or saturated)
//   carry    : carry-out of the raw addition
module lab1_imul_sat_adder #(
  parameter int unsigned p_nbits = 32
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  output logic [p_nbits-1:0] sum,
  output logic               carry
);

  logic [p_nbits:0] raw;

  always_comb begin
    raw   = {1'b0, in0} + {1'b0, in1};
    carry = raw[p_nbits];
`ifdef LAB1_IMUL_DOT_ACCUM_SAT_EN
    // Once the accumulator reaches all-ones, any further non-zero add carries
    // out again, so the value sticks until the group is drained.
    sum = carry ? {p_nbits{1'b1}} : raw[p_nbits-1:0];
`else
    sum = raw[p_nbits-1:0];
`endif
  end

endmodule

// File: rtl/lab1_imul_dot_accum.sv
// Dot-product accumulator: sums each group of p_nelems products from the
// multiplier's output stream and emits one result per group on a val/rdy stream.
// Build option: LAB1_IMUL_DOT_ACCUM_SAT_EN selects a saturating accumulate.
// Ports:
//   clk, reset                           : clock, synchronous active-high reset
//   istream_val/istream_rdy/istream_msg  : product input stream
//   ostream_val/ostream_rdy/ostream_msg  : dot-product result stream
module lab1_imul_dot_accum
  import lab1_imul_dot_accum_pkg::*;
#(
  parameter int unsigned p_nelems = 4,
  parameter int unsigned p_nbits  = 32
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [p_nbits-1:0] istream_msg,

  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg
);

  localparam int unsigned           c_count_w = $clog2(p_nelems + 1);
  localparam logic [c_count_w-1:0] c_last    = c_count_w'(p_nelems - 1);
  localparam logic [c_count_w-1:0] c_one     = c_count_w'(1);

  state_e               state_q, state_d;
  logic [p_nbits-1:0]   acc_q, acc_d;
  logic [c_count_w-1:0] count_q, count_d;

  logic                 in_fire;
  logic                 out_fire;
  logic [p_nbits-1:0]   add_sum;
  logic                 unused_add_carry;

  lab1_imul_sat_adder #(
    .p_nbits (p_nbits)
  ) u_adder (
    .in0   (acc_q),
    .in1   (istream_msg),
    .sum   (add_sum),
    .carry (unused_add_carry)
  );

  // Handshake signals decoded directly from the state register.
  always_comb begin
    istream_rdy = (state_q == ACCUM);
    ostream_val = (state_q == DONE);
    ostream_msg = acc_q;
    in_fire     = istream_val & istream_rdy;
    out_fire    = ostream_val & ostream_rdy;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    unique case (state_q)
      ACCUM: begin
        if (in_fire) begin
          acc_d   = add_sum;
          count_d = count_q + c_one;
          if (count_q == c_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Result is held until the consumer takes it.
        if (out_fire) begin
          acc_d   = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: begin
        acc_d   = '0;
        count_d = '0;
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  // istream val/rdy:msg (A|D count) ostream val/rdy:msg
  function automatic string line_trace();
    return $sformatf("%0b%0b:%h (%s%0d) %0b%0b:%h",
                     istream_val, istream_rdy, istream_msg,
                     (state_q == DONE) ? "D" : "A", count_q,
                     ostream_val, ostream_rdy, ostream_msg);
  endfunction
`endif

endmodule
